// File: rtl/ps2_kbd_pkg.sv
// ---------------------------------------------------------------------------
// ps2_kbd_pkg
// Shared constants and types for the PS/2 to ZX Spectrum keyboard bridge:
//   - PS/2 prefix and self-test (BAT) byte codes
//   - matrix positions of the two shift keys (CS, SS)
//   - receiver frame state enum
//   - key_pos_t: result of a scan-code lookup
// ---------------------------------------------------------------------------
package ps2_kbd_pkg;

    localparam logic [7:0] CODE_EXT      = 8'hE0;
    localparam logic [7:0] CODE_REL      = 8'hF0;
    localparam logic [7:0] CODE_BAT_OK   = 8'hAA;
    localparam logic [7:0] CODE_BAT_FAIL = 8'hFC;

    // Caps Shift sits at row 0 column 0, Symbol Shift at row 7 column 1.
    localparam logic [2:0] CS_ROW = 3'd0;
    localparam logic [2:0] CS_COL = 3'd0;
    localparam logic [2:0] SS_ROW = 3'd7;
    localparam logic [2:0] SS_COL = 3'd1;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

endpackage

// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
// PS/2 device-to-host byte receiver.
//   clk14, rst      : system clock, synchronous active-high reset
//   ps2_clk/ps2_dat : raw asynchronous PS/2 lines
//   byte_valid      : one-cycle pulse with byte_data holding a good byte
//   byte_data       : received byte (LSB first on the wire)
//   rx_error        : one-cycle pulse when a frame is discarded
// Parameters: FILTER_LEN (equal samples to accept a clock level),
//             TIMEOUT_CYC (max cycles between clock falls inside a frame).
// ---------------------------------------------------------------------------
module ps2_rx
    import ps2_kbd_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 14000
) (
    input  logic       clk14,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       rx_error
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_filt;
    logic [FW-1:0] flt_cnt;
    logic          strobe;
    rx_state_t     state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [TW-1:0] gap_cnt;

    // The filtered clock is about to fall this cycle: that is the bit strobe.
    assign strobe = clk_filt && !clk_sync[1] && (flt_cnt == FW'(FILTER_LEN - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk14) begin
        if (rst) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_filt   <= 1'b1;
            flt_cnt    <= '0;
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            gap_cnt    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            rx_error   <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            dat_sync   <= {dat_sync[0], ps2_dat};
            byte_valid <= 1'b0;
            rx_error   <= 1'b0;

            // Level filter: a new clock level must persist FILTER_LEN samples.
            if (clk_sync[1] == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end

            if (state == RX_IDLE || strobe) gap_cnt <= '0;
            else                            gap_cnt <= gap_cnt + 1'b1;

            case (state)
                RX_IDLE: begin
                    if (strobe && !dat_sync[1]) begin
                        state   <= RX_DATA;
                        bit_cnt <= '0;
                    end
                end
                RX_DATA: begin
                    if (strobe) begin
                        shift   <= {dat_sync[1], shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    if (strobe) begin
                        // Odd parity: data plus parity bit hold an odd count of ones.
                        if (^{shift, dat_sync[1]}) begin
                            state <= RX_STOP;
                        end else begin
                            rx_error <= 1'b1;
                            state    <= RX_IDLE;
                        end
                    end
                end
                RX_STOP: begin
                    if (strobe) begin
                        if (dat_sync[1]) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift;
                        end else begin
                            rx_error <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase

            // A stalled frame is abandoned; this overrides the case above.
            if (state != RX_IDLE && !strobe && gap_cnt == TW'(TIMEOUT_CYC - 1)) begin
                rx_error <= 1'b1;
                state    <= RX_IDLE;
            end
        end
    end

endmodule

// File: rtl/ps2_zx_keyboard.sv
// ---------------------------------------------------------------------------
// ps2_zx_keyboard
// PS/2 (scan set 2) keyboard to ZX Spectrum 8x5 key matrix.
//   clk14, rst : system clock, synchronous active-high reset
//   ps2_clk    : raw PS/2 clock        ps2_dat : raw PS/2 data
//   addr_hi    : CPU A15..A8, a 0 bit selects that half-row (A8 = row 0)
//   kd         : active-low column data, registered
//   key_reset  : high while Ctrl, Alt and Del are all held, registered
//   rx_error   : one-cycle pulse per discarded frame
// Optional build macro PS2_EXTENDED_KEYS_EN adds virtual keys: Backspace
// (CS+0) and the four arrows (CS+5..8), each held in its own bit and ORed
// into the matrix.
// ---------------------------------------------------------------------------
module ps2_zx_keyboard
    import ps2_kbd_pkg::*;
#(
    parameter int CLK_FREQ   = 14_000_000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 1000
) (
    input  logic       clk14,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic [7:0] addr_hi,
    output logic [4:0] kd,
    output logic       key_reset,
    output logic       rx_error
);

    localparam int TIMEOUT_CYC = CLK_FREQ / 1_000_000 * TIMEOUT_US;

    logic            byte_valid;
    logic [7:0]      byte_data;
    logic            rel_flag;
    logic            ext_flag;
    logic            ctrl_held;
    logic            alt_held;
    logic            del_held;
    logic [7:0][4:0] pressed;
    logic [7:0][4:0] virt_matrix;
    logic [7:0][4:0] matrix;
    logic [4:0]      col_or;
    logic            clear_all;
    logic            key_event;
    key_pos_t        kp;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk14     (clk14),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .rx_error  (rx_error)
    );

    function automatic key_pos_t at(input int r, input int c);
        return '{hit: 1'b1, row: 3'(r), col: 3'(c)};
    endfunction

    // {ext, code} to matrix position. Both Ctrl keys land on SS.
    function automatic key_pos_t lookup(input logic ext, input logic [7:0] code);
        key_pos_t p;
        p = '{hit: 1'b0, row: 3'd0, col: 3'd0};
        if (code == 8'h14) begin
            p = '{hit: 1'b1, row: SS_ROW, col: SS_COL};
        end else if (!ext) begin
            case (code)
                8'h12, 8'h59: p = '{hit: 1'b1, row: CS_ROW, col: CS_COL};
                8'h1A: p = at(0, 1);  8'h22: p = at(0, 2);
                8'h21: p = at(0, 3);  8'h2A: p = at(0, 4);
                8'h1C: p = at(1, 0);  8'h1B: p = at(1, 1);
                8'h23: p = at(1, 2);  8'h2B: p = at(1, 3);  8'h34: p = at(1, 4);
                8'h15: p = at(2, 0);  8'h1D: p = at(2, 1);
                8'h24: p = at(2, 2);  8'h2D: p = at(2, 3);  8'h2C: p = at(2, 4);
                8'h16: p = at(3, 0);  8'h1E: p = at(3, 1);
                8'h26: p = at(3, 2);  8'h25: p = at(3, 3);  8'h2E: p = at(3, 4);
                8'h45: p = at(4, 0);  8'h46: p = at(4, 1);
                8'h3E: p = at(4, 2);  8'h3D: p = at(4, 3);  8'h36: p = at(4, 4);
                8'h4D: p = at(5, 0);  8'h44: p = at(5, 1);
                8'h43: p = at(5, 2);  8'h3C: p = at(5, 3);  8'h35: p = at(5, 4);
                8'h5A: p = at(6, 0);  8'h4B: p = at(6, 1);
                8'h42: p = at(6, 2);  8'h3B: p = at(6, 3);  8'h33: p = at(6, 4);
                8'h29: p = at(7, 0);  8'h3A: p = at(7, 2);
                8'h31: p = at(7, 3);  8'h32: p = at(7, 4);
                default: p = '{hit: 1'b0, row: 3'd0, col: 3'd0};
            endcase
        end
        return p;
    endfunction

    assign kp        = lookup(ext_flag, byte_data);
    assign clear_all = byte_valid && (byte_data == CODE_BAT_OK || byte_data == CODE_BAT_FAIL);
    assign key_event = byte_valid && !clear_all
                       && byte_data != CODE_EXT && byte_data != CODE_REL;

`ifdef PS2_EXTENDED_KEYS_EN
    // [0] Backspace, [1] left, [2] down, [3] up, [4] right.
    logic [4:0] virt;
    logic [4:0] virt_hit;

    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        virt_hit = '0;
        if (!ext_flag && byte_data == 8'h66) virt_hit[0] = 1'b1;
        if (ext_flag) begin
            case (byte_data)
                8'h6B:   virt_hit[1] = 1'b1;
                8'h72:   virt_hit[2] = 1'b1;
                8'h75:   virt_hit[3] = 1'b1;
                8'h74:   virt_hit[4] = 1'b1;
                default: virt_hit    = '0;
            endcase
        end
    end

    always_ff @(posedge clk14) begin
        if (rst || clear_all) virt <= '0;
        else if (key_event)   virt <= rel_flag ? (virt & ~virt_hit) : (virt | virt_hit);
    end

    always_comb begin
        virt_matrix                 = '0;
        virt_matrix[CS_ROW][CS_COL] = |virt;
        virt_matrix[4][0]           = virt[0];
        virt_matrix[3][4]           = virt[1];
        virt_matrix[4][4]           = virt[2];
        virt_matrix[4][3]           = virt[3];
        virt_matrix[4][2]           = virt[4];
    end
`else
    assign virt_matrix = '0;
`endif

    assign matrix = pressed | virt_matrix;

    always_comb begin
        col_or = '0;
        for (int r = 0; r < 8; r++) begin
            if (!addr_hi[r]) col_or = col_or | matrix[r];
        end
    end

    // The matrix is a small register bank, not a RAM, so it is cleared by reset.
    always_ff @(posedge clk14) begin
        if (rst) begin
            pressed   <= '0;
            rel_flag  <= 1'b0;
            ext_flag  <= 1'b0;
            ctrl_held <= 1'b0;
            alt_held  <= 1'b0;
            del_held  <= 1'b0;
            kd        <= 5'b11111;
            key_reset <= 1'b0;
        end else begin
            kd        <= ~col_or;
            key_reset <= ctrl_held & alt_held & del_held;

            if (rx_error) begin
                rel_flag <= 1'b0;
                ext_flag <= 1'b0;
            end else if (byte_valid) begin
                if (byte_data == CODE_EXT) begin
                    ext_flag <= 1'b1;
                end else if (byte_data == CODE_REL) begin
                    rel_flag <= 1'b1;
                end else begin
                    rel_flag <= 1'b0;
                    ext_flag <= 1'b0;
                end
            end

            if (clear_all) begin
                pressed   <= '0;
                ctrl_held <= 1'b0;
                alt_held  <= 1'b0;
                del_held  <= 1'b0;
            end else if (key_event) begin
                if (kp.hit) pressed[kp.row][kp.col] <= !rel_flag;
                if (byte_data == 8'h14)             ctrl_held <= !rel_flag;
                if (byte_data == 8'h11)             alt_held  <= !rel_flag;
                if (ext_flag && byte_data == 8'h71) del_held  <= !rel_flag;
            end
        end
    end

endmodule

// File: tb/tb_ps2_zx_keyboard.sv
// ---------------------------------------------------------------------------
// tb_ps2_zx_keyboard
// Self-checking bench: reset state, a table of key/address vectors, hand
// sequences for framing errors, timeout, reset mid-frame and kd latency,
// then random key traffic against a matrix model built from the key layout.
// ---------------------------------------------------------------------------
module tb_ps2_zx_keyboard;

    localparam int HALF = 16;   // PS/2 clock half period in clk14 cycles
    localparam int GAP  = 20;   // idle cycles after each frame

    logic       clk14 = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] addr_hi = 8'hFF;
    logic [4:0] kd;
    logic       key_reset;
    logic       rx_error;

    always #5 clk14 = ~clk14;

    // 1 MHz nominal and 100 us gives a 100-cycle frame timeout.
    ps2_zx_keyboard #(
        .CLK_FREQ  (1_000_000),
        .FILTER_LEN(8),
        .TIMEOUT_US(100)
    ) dut (
        .clk14    (clk14),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .addr_hi  (addr_hi),
        .kd       (kd),
        .key_reset(key_reset),
        .rx_error (rx_error)
    );

    int n_checks   = 0;
    int n_fail     = 0;
    int err_pulses = 0;

    always @(posedge clk14) if (rx_error === 1'b1) err_pulses++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- PS/2 host-side driver ----------------
    task automatic ps2_bit(input logic b);
        @(negedge clk14) ps2_dat = b;
        repeat (HALF) @(negedge clk14);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk14);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
        ps2_dat = 1'b1;
        repeat (GAP) @(negedge clk14);
    endtask

    task automatic send_key(input logic ext, input logic rel, input logic [7:0] code);
        if (ext) send_frame(8'hE0, 1'b0, 1'b0);
        if (rel) send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(code, 1'b0, 1'b0);
    endtask

    task automatic read_kd(input logic [7:0] a);
        addr_hi = a;
        repeat (3) @(negedge clk14);
    endtask

    // ---------------- Reference model ----------------
    logic [7:0] key_tab [8][5];
    logic [4:0] m_mtx [8];
    logic       m_ctrl, m_alt, m_del;

    function automatic void model_apply(input logic ext, input logic rel, input logic [7:0] code);
        if (code == 8'hAA || code == 8'hFC) begin
            for (int r = 0; r < 8; r++) m_mtx[r] = '0;
            m_ctrl = 1'b0; m_alt = 1'b0; m_del = 1'b0;
            return;
        end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                if (!ext && key_tab[r][c] == code) m_mtx[r][c] = !rel;
        if (!ext && code == 8'h59) m_mtx[0][0] = !rel;
        if (ext && code == 8'h14)  m_mtx[7][1] = !rel;
        if (code == 8'h14)         m_ctrl = !rel;
        if (code == 8'h11)         m_alt  = !rel;
        if (ext && code == 8'h71)  m_del  = !rel;
    endfunction

    function automatic logic [4:0] model_kd(input logic [7:0] a);
        logic [4:0] acc;
        acc = '0;
        for (int r = 0; r < 8; r++) if (!a[r]) acc |= m_mtx[r];
        return ~acc;
    endfunction

    // ---------------- Vector table ----------------
    typedef struct {
        logic       ext;
        logic       rel;
        logic [7:0] code;
        logic [7:0] addr;
        logic [4:0] kd;
        logic       krst;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #900_000;
        $display("FAIL watchdog: bench did not complete within its time limit");
        $fatal(1);
    end

    initial begin
        int e0;
        logic [8:0] extras [10];
        logic [7:0] a;
        logic       ext, rel;
        logic [7:0] code;
        int         sel;

        key_tab = '{'{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A},
                    '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},
                    '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C},
                    '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},
                    '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36},
                    '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},
                    '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33},
                    '{8'h29, 8'h14, 8'h3A, 8'h31, 8'h32}};
        for (int r = 0; r < 8; r++) m_mtx[r] = '0;
        m_ctrl = 1'b0; m_alt = 1'b0; m_del = 1'b0;

        //             ext   rel   code    addr   kd        krst
        vecs[0]  = '{1'b0, 1'b0, 8'h1C, 8'hFD, 5'b11110, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h1C, 8'hFD, 5'b11111, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h12, 8'hFE, 5'b11110, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h1A, 8'hFE, 5'b11100, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'h22, 8'hFE, 5'b11000, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'h12, 8'hFF, 5'b11111, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h1A, 8'hFE, 5'b11011, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h22, 8'h00, 5'b11111, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h14, 8'h7F, 5'b11101, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h11, 8'h7F, 5'b11101, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 8'h71, 8'h7F, 5'b11101, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 8'h11, 8'h7F, 5'b11101, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 8'h14, 8'h7F, 5'b11111, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 8'h2A, 8'hFE, 5'b01111, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 8'h45, 8'hEE, 5'b01110, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 8'hAA, 8'h00, 5'b11111, 1'b0};

        extras = '{{1'b0, 8'h59}, {1'b1, 8'h14}, {1'b0, 8'h11}, {1'b1, 8'h11},
                   {1'b1, 8'h71}, {1'b0, 8'h76}, {1'b1, 8'h1C}, {1'b0, 8'h05},
                   {1'b0, 8'hAA}, {1'b1, 8'h5A}};

        // ---- Reset state ----
        repeat (5) @(negedge clk14);
        rst = 1'b0;
        read_kd(8'h00);
        check("reset_kd", 32'(kd), 32'h1F);
        check("reset_key_reset", 32'(key_reset), 32'h0);
        check("reset_rx_error", 32'(rx_error), 32'h0);

        // ---- Table-driven vectors ----
        for (int i = 0; i < 16; i++) begin
            send_key(vecs[i].ext, vecs[i].rel, vecs[i].code);
            read_kd(vecs[i].addr);
            check($sformatf("vec%0d_kd", i), 32'(kd), 32'(vecs[i].kd));
            check($sformatf("vec%0d_key_reset", i), 32'(key_reset), 32'(vecs[i].krst));
        end

        // ---- kd latency: one cycle from addr_hi ----
        send_key(1'b0, 1'b0, 8'h1C);
        read_kd(8'hFF);
        @(negedge clk14) addr_hi = 8'hFD;
        #1 check("latency_before", 32'(kd), 32'h1F);
        @(negedge clk14) check("latency_after", 32'(kd), 32'h1E);
        send_key(1'b0, 1'b1, 8'h1C);

        // ---- Bad parity on 0x29 ----
        e0 = err_pulses;
        send_frame(8'h29, 1'b1, 1'b0);
        check("parity_err_pulses", 32'(err_pulses - e0), 32'd1);
        read_kd(8'h7F);
        check("parity_key_dropped", 32'(kd), 32'h1F);
        send_frame(8'h29, 1'b0, 1'b0);
        read_kd(8'h7F);
        check("space_after_parity", 32'(kd), 32'h1E);
        check("no_extra_err", 32'(err_pulses - e0), 32'd1);
        send_key(1'b0, 1'b1, 8'h29);

        // ---- Bad stop bit ----
        e0 = err_pulses;
        send_frame(8'h1C, 1'b0, 1'b1);
        check("stop_err_pulses", 32'(err_pulses - e0), 32'd1);
        read_kd(8'hFD);
        check("stop_key_dropped", 32'(kd), 32'h1F);

        // ---- Timeout after F0: prefix must be forgotten ----
        send_frame(8'hF0, 1'b0, 1'b0);
        e0 = err_pulses;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_dat = 1'b1;
        repeat (150) @(negedge clk14);
        check("timeout_err_pulses", 32'(err_pulses - e0), 32'd1);
        send_frame(8'h1C, 1'b0, 1'b0);
        read_kd(8'hFD);
        check("after_timeout_make", 32'(kd), 32'h1E);

        // ---- Reset mid-frame (A still held) ----
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        @(negedge clk14) rst = 1'b1;
        repeat (3) @(negedge clk14);
        rst = 1'b0;
        ps2_dat = 1'b1;
        e0 = err_pulses;
        read_kd(8'hFD);
        check("midreset_kd", 32'(kd), 32'h1F);
        repeat (150) @(negedge clk14);
        check("midreset_no_err", 32'(err_pulses - e0), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b0);
        read_kd(8'hFD);
        check("midreset_new_frame", 32'(kd), 32'h1E);
        send_key(1'b0, 1'b1, 8'h1C);

        // ---- Virtual arrow keys ----
`ifdef PS2_EXTENDED_KEYS_EN
        send_key(1'b0, 1'b0, 8'h12);
        send_key(1'b1, 1'b0, 8'h6B);
        read_kd(8'hFE); check("arrow_cs_held", 32'(kd), 32'h1E);
        read_kd(8'hF7); check("arrow_5_pressed", 32'(kd), 32'h0F);
        send_key(1'b1, 1'b1, 8'h6B);
        read_kd(8'hFE); check("arrow_rel_cs_kept", 32'(kd), 32'h1E);
        read_kd(8'hF7); check("arrow_5_released", 32'(kd), 32'h1F);
        send_key(1'b0, 1'b1, 8'h12);
        send_key(1'b1, 1'b0, 8'h6B);
        send_key(1'b0, 1'b0, 8'h12);
        send_key(1'b0, 1'b1, 8'h12);
        read_kd(8'hFE); check("shift_rel_virt_kept", 32'(kd), 32'h1E);
        send_key(1'b1, 1'b1, 8'h6B);
        read_kd(8'hFE); check("virt_all_released", 32'(kd), 32'h1F);
`else
        send_key(1'b1, 1'b0, 8'h6B);
        read_kd(8'hF7); check("arrow_ignored_r3", 32'(kd), 32'h1F);
        read_kd(8'hFE); check("arrow_ignored_cs", 32'(kd), 32'h1F);
        send_key(1'b1, 1'b1, 8'h6B);
`endif

        // ---- Random traffic against the model ----
        send_key(1'b0, 1'b0, 8'hAA);
        model_apply(1'b0, 1'b0, 8'hAA);
        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(49, 0));
            rel = 1'($urandom_range(1, 0));
            if (sel < 40) begin
                ext  = 1'b0;
                code = key_tab[sel / 5][sel % 5];
            end else begin
                ext  = extras[sel - 40][8];
                code = extras[sel - 40][7:0];
            end
            send_key(ext, rel, code);
            model_apply(ext, rel, code);
            a = 8'($urandom);
            read_kd(a);
            check($sformatf("rand%0d_kd_addr%02h", i, a), 32'(kd), 32'(model_kd(a)));
            check($sformatf("rand%0d_key_reset", i), 32'(key_reset),
                  32'(m_ctrl & m_alt & m_del));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
